// File: rtl/barrel_derotator_aligner.sv
// barrel_derotator_aligner
// Finds a rotated sync word in an incoming word stream, confirms frame
// alignment over several frames, then de-rotates payload words back to
// their original bit order. Reports lock status and the rotation amount.
module barrel_derotator_aligner #(
  parameter int                 WIDTH      = 8,
  parameter int                 AMT_W      = $clog2(WIDTH),
  parameter logic [WIDTH-1:0]   SYNC_WORD  = 8'hB4,
  parameter int                 FRAME_LEN  = 4,
  parameter int                 LOCK_COUNT = 3,
  parameter int                 LOSS_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             sync_hit,
  output logic             locked,
  output logic [AMT_W-1:0] rot_amt
);

  localparam int POS_W  = $clog2(FRAME_LEN);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t             r_state;
  logic [POS_W-1:0]   r_pos;
  logic [GOOD_W-1:0]  r_good;
  logic [BAD_W-1:0]   r_bad;
  logic [AMT_W-1:0]   r_rot;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_sync_hit;
  logic               r_locked;

  state_t             w_state_nxt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic [GOOD_W-1:0]  w_good_nxt;
  logic [BAD_W-1:0]   w_bad_nxt;
  logic [AMT_W-1:0]   w_rot_nxt;
  logic               w_out_valid_nxt;
  logic [WIDTH-1:0]   w_data_out_nxt;
  logic               w_sync_hit_nxt;

  logic               w_hunt_hit;
  logic [AMT_W-1:0]   w_hunt_amt;
  logic [WIDTH-1:0]   w_derot;
  logic               w_sync_match;
  logic [POS_W-1:0]   w_pos_inc;
  logic [GOOD_W-1:0]  w_good_inc;
  logic [BAD_W-1:0]   w_bad_inc;

  // Undo the transmitter rotation: right when it rotated left (d=0), left otherwise.
  function automatic logic [WIDTH-1:0] derotate(
    input logic [WIDTH-1:0] w,
    input logic [AMT_W-1:0] r,
    input logic             d
  );
    logic [2*WIDTH-1:0] dbl;
    dbl = {w, w};
    if (!d) begin
      dbl = dbl >> r;
      return dbl[WIDTH-1:0];
    end else begin
      dbl = dbl << r;
      return dbl[2*WIDTH-1:WIDTH];
    end
  endfunction

  // Parallel sync search over every rotation; descending loop leaves the lowest match.
  always_comb begin
    w_hunt_hit = 1'b0;
    w_hunt_amt = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (derotate(data_in, AMT_W'(i - 1), dir) == SYNC_WORD) begin
        w_hunt_hit = 1'b1;
        w_hunt_amt = AMT_W'(i - 1);
      end
    end
  end

  // Datapath at the currently detected rotation and counter increments.
  always_comb begin
    w_derot      = derotate(data_in, r_rot, dir);
    w_sync_match = (w_derot == SYNC_WORD);
    w_pos_inc    = (r_pos == POS_W'(FRAME_LEN - 1)) ? '0 : r_pos + POS_W'(1);
    w_good_inc   = r_good + GOOD_W'(1);
    w_bad_inc    = r_bad + BAD_W'(1);
  end

  // Next-state and registered-output decisions; only valid words are evaluated.
  always_comb begin
    w_state_nxt     = r_state;
    w_pos_nxt       = r_pos;
    w_good_nxt      = r_good;
    w_bad_nxt       = r_bad;
    w_rot_nxt       = r_rot;
    w_out_valid_nxt = 1'b0;
    w_data_out_nxt  = r_data_out;
    w_sync_hit_nxt  = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_hunt_hit) begin
            w_rot_nxt   = w_hunt_amt;
            w_pos_nxt   = POS_W'(1);
            w_good_nxt  = GOOD_W'(1);
            w_bad_nxt   = '0;
            w_state_nxt = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          w_pos_nxt = w_pos_inc;
          if (r_pos == '0) begin
            if (w_sync_match) begin
              w_sync_hit_nxt = 1'b1;
              w_good_nxt     = w_good_inc;
              if (w_good_inc == GOOD_W'(LOCK_COUNT)) begin
                w_state_nxt = ST_LOCKED;
                w_bad_nxt   = '0;
              end
            end else begin
              w_state_nxt = ST_HUNT;
              w_good_nxt  = '0;
            end
          end
        end
        ST_LOCKED: begin
          w_pos_nxt = w_pos_inc;
          if (r_pos == '0) begin
            if (w_sync_match) begin
              w_sync_hit_nxt = 1'b1;
              w_bad_nxt      = '0;
            end else if (w_bad_inc == BAD_W'(LOSS_COUNT)) begin
              w_state_nxt = ST_HUNT;
              w_bad_nxt   = '0;
              w_good_nxt  = '0;
            end else begin
              w_bad_nxt = w_bad_inc;
            end
          end else begin
            w_out_valid_nxt = 1'b1;
            w_data_out_nxt  = w_derot;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_HUNT;
      r_pos       <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_rot       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_sync_hit  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_good      <= w_good_nxt;
      r_bad       <= w_bad_nxt;
      r_rot       <= w_rot_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_data_out  <= w_data_out_nxt;
      r_sync_hit  <= w_sync_hit_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign sync_hit  = r_sync_hit;
  assign locked    = r_locked;
  assign rot_amt   = r_rot;

endmodule
